seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
- Multi-cycle sequencer for the SEQ Y86-64 core.
- Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, issuing a one-cycle enable for each stage.
- Uses the fetch/decode unit's outputs (icode, instructionValid, imem_error) to pick the stage path and the processor status.
- Sits between the top-level run control and the datapath register/PC enables; also owns the data-memory request handshake.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEMORY waiting for dmem_ack before ADR fault (1..255)
CNT_W, 32, width of cycle_count and instr_count

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin execution from IDLE (level, sampled in IDLE only)
clear  input  1  leave HALT back to IDLE and restore stat to AOK
icode  input  4  decoded instruction code from fetch/decode unit
instructionValid  input  1  decoder says icode/ifun legal
imem_error  input  1  instruction fetch address fault
dmem_ack  input  1  data memory completed request this cycle
dmem_error  input  1  data memory fault, qualified by dmem_ack
fetch_en  output  1  one-cycle strobe: latch instruction bytes
decode_en  output  1  one-cycle strobe: register file read
execute_en  output  1  one-cycle strobe: ALU/CC update
dmem_req  output  1  held high for the whole MEMORY state
writeback_en  output  1  one-cycle strobe: register file write
pc_en  output  1  one-cycle strobe: PC <= newPC
stat  output  3  1=AOK 2=HLT 3=ADR 4=INS
halted  output  1  high in HALT state
cycle_count  output  CNT_W  clocks spent outside IDLE/HALT
instr_count  output  CNT_W  instructions retired (pc_en pulses)

Behaviour:
Reset:
- Async on reset_n low: state=IDLE, stat=1, all strobes 0, dmem_req 0, halted 0, both counters 0.
- Reset mid-instruction aborts immediately; no partial strobes afterwards.

States and transitions:
- IDLE: no strobes. If start=1 -> FETCH; else stay. clear is ignored here.
- FETCH: fetch_en=1 -> DECODE.
- DECODE: decode_en=1. icode, instructionValid and imem_error are sampled in this cycle, evaluated in priority order:
  - imem_error -> HALT, stat=3
  - !instructionValid -> HALT, stat=4
  - icode==0 -> HALT, stat=2
  - otherwise -> EXECUTE
  - On any fault or halt: no execute_en, no writeback_en, no pc_en, and instr_count is not incremented.
- EXECUTE: execute_en=1. icode in {4,5,8,9,A,B} -> MEMORY; else -> WRITEBACK.
- MEMORY: dmem_req=1 every cycle in this state; a wait counter starts at 0 on entry.
  - dmem_ack && dmem_error -> HALT, stat=3
  - dmem_ack -> WRITEBACK
  - wait counter reaches MEM_TIMEOUT-1 without ack -> HALT, stat=3
  - An ack in the same cycle as the timeout wins.
- WRITEBACK: writeback_en=1 -> PCUPDATE.
- PCUPDATE: pc_en=1, instr_count+1 -> FETCH. start is not re-sampled; the core free-runs until halt or fault.
- HALT: halted=1, stat held. clear=1 -> IDLE with stat=1; counters keep their values (reset only by reset_n).

Timing and counters:
- Latency: non-memory instruction = 5 cycles FETCH..PCUPDATE; memory instruction = 6 + wait cycles.
- Strobes are Moore outputs, mutually exclusive, glitch-free (registered state decode).
- cycle_count increments in every state except IDLE and HALT; it wraps modulo 2^CNT_W.
- instr_count also wraps modulo 2^CNT_W.
- icode is only sampled in DECODE and EXECUTE; it may change freely otherwise.

Test Plan:
- Reset, start=1, icode=1 valid, 3 instructions -> strobes in order fetch,decode,execute,writeback,pc per instruction; pc_en at cycles 5, 10, 15 after start; instr_count=3; stat=1.
- icode=5 with dmem_ack asserted 3 cycles into MEMORY -> dmem_req high exactly 4 cycles; writeback_en follows next cycle; instruction takes 9 cycles total.
- icode=4, dmem_ack never asserted, MEM_TIMEOUT=16 -> dmem_req high 16 cycles, then HALT, stat=3, no writeback_en or pc_en, instr_count unchanged.
- Separate runs, one per fault in DECODE: imem_error=1 (even with icode=0) -> stat=3; instructionValid=0 -> stat=4; icode=0 -> stat=2. Each ends with halted=1 and no execute_en.
- In HALT assert clear -> next cycle IDLE, stat=1, halted=0, counters retained; then start -> fetch_en next cycle.
- reset_n low during MEMORY with dmem_req=1 -> dmem_req drops asynchronously; state=IDLE; counters 0; no strobe after release until start.

Source files
------------

// File: rtl/seq_stage_controller_if.sv
// Stage strobes, decode status and data-memory handshake shared between
// the SEQ stage controller (master) and the datapath (slave).
interface seq_stage_controller_if;
  logic [3:0] icode;
  logic       instructionValid;
  logic       imem_error;
  logic       dmem_ack;
  logic       dmem_error;
  logic       fetch_en;
  logic       decode_en;
  logic       execute_en;
  logic       dmem_req;
  logic       writeback_en;
  logic       pc_en;

  modport master (
    input  icode, instructionValid, imem_error, dmem_ack, dmem_error,
    output fetch_en, decode_en, execute_en, dmem_req, writeback_en, pc_en
  );

  modport slave (
    output icode, instructionValid, imem_error, dmem_ack, dmem_error,
    input  fetch_en, decode_en, execute_en, dmem_req, writeback_en, pc_en
  );
endinterface

// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ Y86-64 sequencer: walks fetch..PC update one instruction at a
// time, issuing one-cycle stage strobes and tracking processor status.
module seq_stage_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  clear,
  seq_stage_controller_if.master bus,
  output logic [2:0]            stat,
  output logic                  halted,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      instr_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALT
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, next_state;
  logic [2:0] next_stat;
  logic [7:0] wait_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      stat        <= STAT_AOK;
      wait_cnt    <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      stat  <= next_stat;
      // Only MEMORY advances the wait counter, so it is always zero on entry.
      wait_cnt <= (state == MEMORY) ? wait_cnt + 8'd1 : 8'd0;
      if (state != IDLE && state != HALT)
        cycle_count <= cycle_count + CNT_W'(1);
      if (state == PCUPDATE)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    next_stat  = stat;
    case (state)
      IDLE:      if (start) next_state = FETCH;
      FETCH:     next_state = DECODE;
      DECODE: begin
        if (bus.imem_error) begin
          next_state = HALT;
          next_stat  = STAT_ADR;
        end else if (!bus.instructionValid) begin
          next_state = HALT;
          next_stat  = STAT_INS;
        end else if (bus.icode == 4'h0) begin
          next_state = HALT;
          next_stat  = STAT_HLT;
        end else begin
          next_state = EXECUTE;
        end
      end
      EXECUTE: begin
        case (bus.icode)
          4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: next_state = MEMORY;
          default:                            next_state = WRITEBACK;
        endcase
      end
      MEMORY: begin
        // An ack arriving on the last allowed cycle beats the timeout.
        if (bus.dmem_ack) begin
          if (bus.dmem_error) begin
            next_state = HALT;
            next_stat  = STAT_ADR;
          end else begin
            next_state = WRITEBACK;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = HALT;
          next_stat  = STAT_ADR;
        end
      end
      WRITEBACK: next_state = PCUPDATE;
      PCUPDATE:  next_state = FETCH;
      HALT: begin
        if (clear) begin
          next_state = IDLE;
          next_stat  = STAT_AOK;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  assign bus.fetch_en     = (state == FETCH);
  assign bus.decode_en    = (state == DECODE);
  assign bus.execute_en   = (state == EXECUTE);
  assign bus.dmem_req     = (state == MEMORY);
  assign bus.writeback_en = (state == WRITEBACK);
  assign bus.pc_en        = (state == PCUPDATE);
  assign halted           = (state == HALT);

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller: per-cycle vector table plus
// hand-written timeout, counter/clear and async-reset sequences.
module tb_seq_stage_controller;
  localparam logic [5:0] SF = 6'b100000;
  localparam logic [5:0] SD = 6'b010000;
  localparam logic [5:0] SE = 6'b001000;
  localparam logic [5:0] SM = 6'b000100;
  localparam logic [5:0] SW = 6'b000010;
  localparam logic [5:0] SP = 6'b000001;
  localparam logic [5:0] S0 = 6'b000000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  seq_stage_controller_if bus ();

  seq_stage_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .clear(clear),
    .bus(bus), .stat(stat), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       start, clear;
    logic [3:0] icode;
    logic       valid, imem_err, ack, derr;
    logic [5:0] exp_str;
    logic [2:0] exp_stat;
    logic       exp_halt;
    int         exp_instr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [5:0] strobes();
    return {bus.fetch_en, bus.decode_en, bus.execute_en,
            bus.dmem_req, bus.writeback_en, bus.pc_en};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic st, input logic cl, input logic [3:0] ic,
                                input logic va, input logic ie, input logic ak, input logic de);
    start = st;
    clear = cl;
    bus.icode = ic;
    bus.instructionValid = va;
    bus.imem_error = ie;
    bus.dmem_ack = ak;
    bus.dmem_error = de;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic v(input logic st, input logic cl, input logic [3:0] ic, input logic va,
                   input logic ie, input logic ak, input logic de,
                   input logic [5:0] s, input logic [2:0] sa, input logic h, input int n);
    vec_t r;
    r.start = st; r.clear = cl; r.icode = ic; r.valid = va; r.imem_err = ie;
    r.ack = ak; r.derr = de; r.exp_str = s; r.exp_stat = sa; r.exp_halt = h;
    r.exp_instr = n;
    vecs.push_back(r);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    apply_stimulus(0, 0, 4'h1, 1, 0, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic seen;
    logic [5:0] acc;

    // Three plain instructions, each F D E W P
    for (int k = 0; k < 3; k++) begin
      v(k == 0, 0, 4'h1, 1, 0, 0, 0, SF, 3'd1, 0, k);
      v(0, 0, 4'h1, 1, 0, 0, 0, SD, 3'd1, 0, k);
      v(0, 0, 4'h1, 1, 0, 0, 0, SE, 3'd1, 0, k);
      v(0, 0, 4'h1, 1, 0, 0, 0, SW, 3'd1, 0, k);
      v(0, 0, 4'h1, 1, 0, 0, 0, SP, 3'd1, 0, k);
    end
    v(0, 0, 4'h0, 1, 0, 0, 0, SF, 3'd1, 0, 3);
    v(0, 0, 4'h0, 1, 0, 0, 0, SD, 3'd1, 0, 3);
    v(0, 0, 4'h0, 1, 0, 0, 0, S0, 3'd2, 1, 3);
    v(0, 0, 4'h0, 1, 0, 0, 0, S0, 3'd2, 1, 3);
    v(0, 1, 4'h0, 1, 0, 0, 0, S0, 3'd1, 0, 3);
    v(0, 1, 4'h0, 1, 0, 0, 0, S0, 3'd1, 0, 3);
    // imem_error outranks icode==0
    v(1, 0, 4'h0, 1, 1, 0, 0, SF, 3'd1, 0, 3);
    v(0, 0, 4'h0, 1, 1, 0, 0, SD, 3'd1, 0, 3);
    v(0, 0, 4'h0, 1, 1, 0, 0, S0, 3'd3, 1, 3);
    v(0, 1, 4'h1, 1, 0, 0, 0, S0, 3'd1, 0, 3);
    v(1, 0, 4'h1, 0, 0, 0, 0, SF, 3'd1, 0, 3);
    v(0, 0, 4'h1, 0, 0, 0, 0, SD, 3'd1, 0, 3);
    v(0, 0, 4'h1, 0, 0, 0, 0, S0, 3'd4, 1, 3);
    v(0, 1, 4'h5, 1, 0, 0, 0, S0, 3'd1, 0, 3);
    // icode 5, ack on fourth MEMORY cycle
    v(1, 0, 4'h5, 1, 0, 0, 0, SF, 3'd1, 0, 3);
    v(0, 0, 4'h5, 1, 0, 0, 0, SD, 3'd1, 0, 3);
    v(0, 0, 4'h5, 1, 0, 0, 0, SE, 3'd1, 0, 3);
    v(0, 0, 4'h5, 1, 0, 0, 0, SM, 3'd1, 0, 3);
    v(0, 0, 4'h5, 1, 0, 0, 0, SM, 3'd1, 0, 3);
    v(0, 0, 4'h5, 1, 0, 0, 0, SM, 3'd1, 0, 3);
    v(0, 0, 4'h5, 1, 0, 0, 0, SM, 3'd1, 0, 3);
    v(0, 0, 4'h5, 1, 0, 1, 0, SW, 3'd1, 0, 3);
    v(0, 0, 4'h9, 1, 0, 0, 0, SP, 3'd1, 0, 3);
    v(0, 0, 4'h9, 1, 0, 0, 0, SF, 3'd1, 0, 4);
    v(0, 0, 4'h9, 1, 0, 0, 0, SD, 3'd1, 0, 4);
    v(0, 0, 4'h9, 1, 0, 0, 0, SE, 3'd1, 0, 4);
    v(0, 0, 4'h9, 1, 0, 0, 0, SM, 3'd1, 0, 4);
    v(0, 0, 4'h9, 1, 0, 1, 1, S0, 3'd3, 1, 4);
    v(0, 1, 4'h4, 1, 0, 0, 0, S0, 3'd1, 0, 4);

    do_reset();
    check_output("reset_strobes", {58'd0, strobes()}, {58'd0, S0});
    check_output("reset_stat", {61'd0, stat}, 64'd1);
    check_output("reset_halted", {63'd0, halted}, 64'd0);
    check_output("reset_cycles", {32'd0, cycle_count}, 64'd0);
    check_output("reset_instrs", {32'd0, instr_count}, 64'd0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].start, vecs[i].clear, vecs[i].icode, vecs[i].valid,
                     vecs[i].imem_err, vecs[i].ack, vecs[i].derr);
      step();
      check_output($sformatf("vec%0d_strobes", i), {58'd0, strobes()}, {58'd0, vecs[i].exp_str});
      check_output($sformatf("vec%0d_stat", i), {61'd0, stat}, {61'd0, vecs[i].exp_stat});
      check_output($sformatf("vec%0d_halted", i), {63'd0, halted}, {63'd0, vecs[i].exp_halt});
      check_output($sformatf("vec%0d_instrs", i), {32'd0, instr_count}, 64'(vecs[i].exp_instr));
    end

    // Memory timeout: icode 4 with no ack ever
    apply_stimulus(1, 0, 4'h4, 1, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 4'h4, 1, 0, 0, 0);
    repeat (3) step();
    n = 0;
    seen = 1'b0;
    while (bus.dmem_req && n < 40) begin
      n++;
      step();
      if (bus.writeback_en || bus.pc_en) seen = 1'b1;
    end
    check_output("timeout_req_cycles", 64'(n), 64'd16);
    check_output("timeout_halted", {63'd0, halted}, 64'd1);
    check_output("timeout_stat", {61'd0, stat}, 64'd3);
    check_output("timeout_no_wb_pc", {63'd0, seen}, 64'd0);
    check_output("timeout_instrs", {32'd0, instr_count}, 64'd4);

    // Counters from a fresh reset, then HALT/clear retention
    do_reset();
    apply_stimulus(1, 0, 4'h1, 1, 0, 0, 0);
    step();
    apply_stimulus(0, 0, 4'h1, 1, 0, 0, 0);
    repeat (10) step();
    check_output("run_fetch", {63'd0, bus.fetch_en}, 64'd1);
    check_output("run_cycles", {32'd0, cycle_count}, 64'd10);
    check_output("run_instrs", {32'd0, instr_count}, 64'd2);
    apply_stimulus(0, 0, 4'h0, 1, 0, 0, 0);
    step();
    step();
    check_output("hlt_halted", {63'd0, halted}, 64'd1);
    check_output("hlt_stat", {61'd0, stat}, 64'd2);
    check_output("hlt_cycles", {32'd0, cycle_count}, 64'd12);
    step();
    check_output("hlt_cycles_frozen", {32'd0, cycle_count}, 64'd12);
    apply_stimulus(0, 1, 4'h0, 1, 0, 0, 0);
    step();
    check_output("clr_halted", {63'd0, halted}, 64'd0);
    check_output("clr_stat", {61'd0, stat}, 64'd1);
    check_output("clr_cycles", {32'd0, cycle_count}, 64'd12);
    check_output("clr_instrs", {32'd0, instr_count}, 64'd2);
    apply_stimulus(1, 0, 4'h8, 1, 0, 0, 0);
    step();
    check_output("restart_fetch", {58'd0, strobes()}, {58'd0, SF});

    // Async reset while MEMORY holds dmem_req
    apply_stimulus(0, 0, 4'h8, 1, 0, 0, 0);
    repeat (3) step();
    check_output("mem_req_before_reset", {63'd0, bus.dmem_req}, 64'd1);
    #3 reset_n = 1'b0;
    #1;
    check_output("async_req_drop", {63'd0, bus.dmem_req}, 64'd0);
    check_output("async_cycles", {32'd0, cycle_count}, 64'd0);
    check_output("async_instrs", {32'd0, instr_count}, 64'd0);
    check_output("async_stat", {61'd0, stat}, 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc = acc | strobes();
    end
    check_output("post_reset_quiet", {58'd0, acc}, {58'd0, S0});
    apply_stimulus(1, 0, 4'h1, 1, 0, 0, 0);
    step();
    check_output("post_reset_fetch", {63'd0, bus.fetch_en}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
